fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch controller sitting directly downstream of the program-counter register. It reads the current PC, issues a word request to instruction memory, captures the returned instruction into an instruction register for the decode stage, and drives the PC register's write enable and next-PC value. It supports PC + 4 sequencing, redirects from the branch/jump logic, a global stall, and a variable-latency memory handshake.

## Interface
- RESET_PC, 32'h00400000, value of `next_pc` while in reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising edge of `clk`; 0 = reset).
- pc  in  32  current PC from the PC register.
- pc_wea  out  1  write enable to the PC register.
- next_pc  out  32  value to be written into the PC register.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  request address; always equals `pc`.
- imem_ready  in  1  memory has `imem_rdata` valid this cycle.
- imem_rdata  in  32  instruction word.
- redirect  in  1  branch/jump/exception redirect this cycle.
- redirect_pc  in  32  redirect target.
- stall  in  1  decode cannot accept a new instruction.
- ir  out  32  instruction register.
- ir_pc  out  32  address `ir` was fetched from.
- ir_valid  out  1  `ir`/`ir_pc` hold an unconsumed instruction.
- ir_ack  in  1  decode consumes `ir` this cycle (honoured only when `ir_valid`=1).
- addr_err  out  1  `ir_pc[1:0]` != 0; qualified by `ir_valid`.

## Operation
- States: RST, REQ, HOLD.
- Reset (rst=0): state←RST; ir←0, ir_pc←0, ir_valid←0, addr_err←0; outputs pc_wea=0, imem_req=0, next_pc=RESET_PC.
- RST: one cycle after rst deasserts; imem_req=0, pc_wea=0; → REQ.
- REQ: imem_req=1. On imem_ready=1 (and no redirect): ir←imem_rdata, ir_pc←pc, addr_err←(pc[1:0]!=0), ir_valid←1; same cycle pc_wea=1, next_pc=pc+4; → HOLD. imem_ready=0: stay, pc_wea=0.
- HOLD: imem_req=0, ir_valid=1. If ir_ack=1 and stall=0: ir_valid←0; → REQ. Otherwise hold all registers.
- Redirect (highest priority, any state except RST and reset): pc_wea=1, next_pc=redirect_pc, ir_valid←0, → REQ. imem_ready/imem_rdata in that cycle are ignored (the in-flight fetch is discarded); ir_ack is ignored.
- Arithmetic: pc+4 is 32-bit modulo 2^32 (0xFFFFFFFC → 0x00000000); no carry out.
- Misaligned addresses are still fetched; addr_err travels with the instruction, and decode raises the exception.
- Outside the cases above, pc_wea=0 and next_pc=pc+4 (don't-care value, but driven deterministically).

## Timing
- pc_wea, next_pc, imem_req and imem_addr are combinational from state and inputs; ir, ir_pc, ir_valid and addr_err are registered.
- Minimum fetch latency: request in cycle N with imem_ready=1 → ir_valid=1 in cycle N+1; the PC register shows pc+4 in N+1.
- Peak throughput: one instruction per 2 cycles (REQ, HOLD).
- ir_ack and stall both high: treated as stall; the instruction is held.
- Redirect in the same cycle as imem_ready: the redirect wins; no instruction is captured, and the PC is loaded with redirect_pc.
- Reset asserted mid-fetch: the next edge forces RST; the pending memory response is ignored.

## Test plan
- Reset then idle memory: rst low 3 cycles → ir_valid=0, pc_wea=0, next_pc=0x00400000; one RST cycle after release, then imem_req=1 with imem_addr=pc.
- Sequential fetch, imem_ready=1 each REQ, ir_ack=1: pc 0x00400000 → ir_pc 0x00400000, 0x00400004, 0x00400008 in successive HOLD cycles; pc_wea pulses every 2 cycles.
- Wait states: imem_ready low 3 cycles → imem_req stays high, pc_wea=0, ir unchanged; capture occurs on the 4th cycle.
- Stall: stall=1 and ir_ack=1 for 4 cycles in HOLD → ir/ir_pc are stable and ir_valid=1; release → REQ next cycle.
- Redirect collision: redirect=1, redirect_pc=0x00400100 in the same cycle as imem_ready=1 → no capture, ir_valid=0, next_pc=0x00400100 with pc_wea=1; the next fetch uses address 0x00400100.
- Misaligned and wrap cases: redirect_pc=0x00400102 → fetched instruction has addr_err=1. pc=0xFFFFFFFC fetch → next_pc=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: PC -> imem request -> instruction register, with redirect and stall.
// Latency: one cycle from an accepted memory response to ir_valid. ir is held until it is consumed with ir_ack while stall is low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_wea,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic        addr_err
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc_inc;
    logic        capture;
    logic        drop_ir;

    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        pc_wea    = 1'b0;
        next_pc   = pc_inc;
        imem_req  = 1'b0;
        state_nxt = state;
        capture   = 1'b0;
        drop_ir   = 1'b0;
        if (!rst) begin
            next_pc   = RESET_PC;
            state_nxt = ST_RST;
        end else begin
            case (state)
                ST_RST: state_nxt = ST_REQ;
                ST_REQ: begin
                    imem_req = 1'b1;
                    // A redirect discards whatever the memory returns this cycle.
                    if (redirect) begin
                        pc_wea  = 1'b1;
                        next_pc = redirect_pc;
                        drop_ir = 1'b1;
                    end else if (imem_ready) begin
                        pc_wea    = 1'b1;
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc_wea    = 1'b1;
                        next_pc   = redirect_pc;
                        drop_ir   = 1'b1;
                        state_nxt = ST_REQ;
                    end else if (ir_ack && !stall) begin
                        drop_ir   = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
                default: state_nxt = ST_RST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RST;
            ir       <= 32'd0;
            ir_pc    <= 32'd0;
            ir_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                ir       <= imem_rdata;
                ir_pc    <= pc;
                addr_err <= |pc[1:0];
                ir_valid <= 1'b1;
            end else if (drop_ir) begin
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the PC register and a simple instruction memory.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = RESET_PC;
    logic        pc_wea;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ack = 1'b0;
    logic        addr_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] held_ir;
    logic [31:0] held_pc;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_wea     (pc_wea),
        .next_pc    (next_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ack     (ir_ack),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Drive one cycle's inputs and let the combinational outputs settle.
    task automatic set_in(input logic rdy, input logic rdr, input logic [31:0] rpc,
                          input logic ack, input logic stl);
        imem_ready  = rdy;
        imem_rdata  = rdy ? mem_word(pc) : 32'hDEAD_BEEF;
        redirect    = rdr;
        redirect_pc = rpc;
        ir_ack      = ack;
        stall       = stl;
        #1;
    endtask

    // Advance one clock, updating the PC register model from the pre-edge outputs.
    task automatic tick();
        logic        w;
        logic        r;
        logic [31:0] n;
        #1;
        w = pc_wea;
        n = next_pc;
        r = rst;
        @(posedge clk);
        #1;
        if (!r) pc = RESET_PC;
        else if (w) pc = n;
    endtask

    task automatic push_fetch();
        sb.push_back('{addr: pc, dat: mem_word(pc), err: |pc[1:0]});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 0, 32'd0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ir_valid !== 1'b0 || pc_wea !== 1'b0 || imem_req !== 1'b0 || next_pc !== RESET_PC
                || ir !== 32'd0 || ir_pc !== 32'd0 || addr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d] got valid=%b wea=%b req=%b next_pc=%h ir=%h ir_pc=%h err=%b want 0/0/0/%h/0/0/0",
                         k, ir_valid, pc_wea, imem_req, next_pc, ir, ir_pc, addr_err, RESET_PC);
            end
            tick();
        end
        rst = 1'b1;
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (imem_req !== 1'b0 || pc_wea !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_state got req=%b wea=%b want 0/0", imem_req, pc_wea);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || pc_wea !== 1'b0) begin
            n_bad++;
            $display("FAIL first_req got req=%b addr=%h wea=%b want 1/%h/0", imem_req, imem_addr, pc_wea, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 32'd0, 1, 0);
            n_cmp++;
            if (pc_wea !== 1'b1 || next_pc !== RESET_PC + 32'(4 * (k + 1))) begin
                n_bad++;
                $display("FAIL seq_wea[%0d] got wea=%b next_pc=%h want 1/%h", k, pc_wea, next_pc, RESET_PC + 32'(4 * (k + 1)));
            end
            push_fetch();
            tick();
            set_in(0, 0, 32'd0, 1, 0);
            e = sb.pop_front();
            n_cmp++;
            if (ir_valid !== 1'b1 || ir !== e.dat || ir_pc !== e.addr || ir_pc !== RESET_PC + 32'(4 * k)
                || addr_err !== e.err || pc_wea !== 1'b0 || imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL seq_capture[%0d] got valid=%b ir=%h ir_pc=%h err=%b wea=%b req=%b want 1/%h/%h/%b/0/0",
                         k, ir_valid, ir, ir_pc, addr_err, pc_wea, imem_req, e.dat, e.addr, e.err);
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        held_ir = ir;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 32'd0, 1, 0);
            n_cmp++;
            if (imem_req !== 1'b1 || pc_wea !== 1'b0 || ir !== held_ir || ir_valid !== 1'b0
                || imem_addr !== 32'h0040000C) begin
                n_bad++;
                $display("FAIL wait[%0d] got req=%b wea=%b ir=%h valid=%b addr=%h want 1/0/%h/0/0040000c",
                         k, imem_req, pc_wea, ir, ir_valid, imem_addr, held_ir);
            end
            tick();
        end
        set_in(1, 0, 32'd0, 0, 0);
        push_fetch();
        tick();
        set_in(0, 0, 32'd0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (ir_valid !== 1'b1 || ir !== e.dat || ir_pc !== 32'h0040000C || addr_err !== e.err) begin
            n_bad++;
            $display("FAIL wait_capture got valid=%b ir=%h ir_pc=%h err=%b want 1/%h/0040000c/%b",
                     ir_valid, ir, ir_pc, addr_err, e.dat, e.err);
        end
    endtask

    task automatic test_stall();
        held_ir = ir;
        held_pc = ir_pc;
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 32'd0, 1, 1);
            n_cmp++;
            if (ir_valid !== 1'b1 || ir !== held_ir || ir_pc !== held_pc || pc_wea !== 1'b0 || imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL stall[%0d] got valid=%b ir=%h ir_pc=%h wea=%b req=%b want 1/%h/%h/0/0",
                         k, ir_valid, ir, ir_pc, pc_wea, imem_req, held_ir, held_pc);
            end
            tick();
        end
        set_in(0, 0, 32'd0, 1, 0);
        tick();
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (imem_req !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== 32'h00400010) begin
            n_bad++;
            $display("FAIL stall_release got req=%b valid=%b addr=%h want 1/0/00400010", imem_req, ir_valid, imem_addr);
        end
    endtask

    task automatic test_redirect();
        set_in(1, 1, 32'h00400100, 1, 0);
        n_cmp++;
        if (pc_wea !== 1'b1 || next_pc !== 32'h00400100) begin
            n_bad++;
            $display("FAIL redir_collide got wea=%b next_pc=%h want 1/00400100", pc_wea, next_pc);
        end
        tick();
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400100) begin
            n_bad++;
            $display("FAIL redir_after got valid=%b req=%b addr=%h want 0/1/00400100", ir_valid, imem_req, imem_addr);
        end
        set_in(1, 0, 32'd0, 0, 0);
        push_fetch();
        tick();
        set_in(0, 1, 32'h00400102, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (ir_valid !== 1'b1 || ir !== e.dat || ir_pc !== 32'h00400100 || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_fetch got valid=%b ir=%h ir_pc=%h err=%b want 1/%h/00400100/0",
                     ir_valid, ir, ir_pc, addr_err, e.dat);
        end
        n_cmp++;
        if (pc_wea !== 1'b1 || next_pc !== 32'h00400102) begin
            n_bad++;
            $display("FAIL redir_hold got wea=%b next_pc=%h want 1/00400102", pc_wea, next_pc);
        end
        tick();
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400102) begin
            n_bad++;
            $display("FAIL redir_hold_after got valid=%b req=%b addr=%h want 0/1/00400102", ir_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_misaligned_wrap();
        set_in(1, 0, 32'd0, 0, 0);
        n_cmp++;
        if (next_pc !== 32'h00400106) begin
            n_bad++;
            $display("FAIL misalign_next got next_pc=%h want 00400106", next_pc);
        end
        push_fetch();
        tick();
        set_in(0, 1, 32'hFFFF_FFFC, 1, 0);
        e = sb.pop_front();
        n_cmp++;
        if (ir_valid !== 1'b1 || addr_err !== 1'b1 || ir_pc !== 32'h00400102 || ir !== e.dat) begin
            n_bad++;
            $display("FAIL misalign_err got valid=%b err=%b ir_pc=%h ir=%h want 1/1/00400102/%h",
                     ir_valid, addr_err, ir_pc, ir, e.dat);
        end
        tick();
        set_in(1, 0, 32'd0, 1, 0);
        n_cmp++;
        if (pc_wea !== 1'b1 || next_pc !== 32'h0000_0000 || imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_next got wea=%b next_pc=%h addr=%h want 1/00000000/fffffffc", pc_wea, next_pc, imem_addr);
        end
        push_fetch();
        tick();
        set_in(0, 0, 32'd0, 1, 0);
        e = sb.pop_front();
        n_cmp++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFF_FFFC || ir !== e.dat || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_capture got valid=%b ir_pc=%h ir=%h err=%b want 1/fffffffc/%h/0",
                     ir_valid, ir_pc, ir, addr_err, e.dat);
        end
        tick();
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL wrap_addr got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_midfetch();
        rst = 1'b0;
        set_in(1, 0, 32'd0, 1, 0);
        n_cmp++;
        if (pc_wea !== 1'b0 || imem_req !== 1'b0 || next_pc !== RESET_PC) begin
            n_bad++;
            $display("FAIL midreset_comb got wea=%b req=%b next_pc=%h want 0/0/%h", pc_wea, imem_req, next_pc, RESET_PC);
        end
        tick();
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (ir_valid !== 1'b0 || ir !== 32'd0 || ir_pc !== 32'd0 || addr_err !== 1'b0 || pc !== RESET_PC) begin
            n_bad++;
            $display("FAIL midreset_regs got valid=%b ir=%h ir_pc=%h err=%b pc=%h want 0/0/0/0/%h",
                     ir_valid, ir, ir_pc, addr_err, pc, RESET_PC);
        end
        rst = 1'b1;
        set_in(0, 0, 32'd0, 0, 0);
        n_cmp++;
        if (imem_req !== 1'b0 || pc_wea !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_rst got req=%b wea=%b want 0/0", imem_req, pc_wea);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL midreset_req got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_redirect();
        test_misaligned_wrap();
        test_reset_midfetch();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
